// File: rtl/sigmoid_feeder.sv
// Serializes packed bf16 words one lane per cycle into the sigmoid unit,
// metering issue with a credit counter that mirrors downstream buffer space.
module sigmoid_feeder #(
    parameter int LANES   = 4,
    parameter int CREDITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*LANES-1:0]      in_data,
    input  logic [$clog2(LANES):0]   in_count,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic [15:0]              out_data,
    output logic                     out_last,
    input  logic                     credit_return,
    output logic [3:0]               credits,
    output logic                     credit_err,
    output logic                     busy
);

    localparam int LW = $clog2(LANES);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] LANES_C  = CW'(LANES);
    localparam logic [3:0]    CRED_MAX = 4'(CREDITS);

    logic [16*LANES-1:0] r_hold_data;
    logic [CW-1:0]       r_hold_count;
    logic                r_hold_last;
    logic                r_hold_valid;
    logic [LW-1:0]       r_lane;
    logic [3:0]          r_cred;
    logic                r_credit_err;

    logic                w_issue;
    logic                w_last_lane;
    logic                w_final;
    logic                w_accept;
    logic [CW-1:0]       w_count;

    assign w_issue     = r_hold_valid && (r_cred != 4'd0);
    assign w_last_lane = ({1'b0, r_lane} == (r_hold_count - CW'(1)));
    assign w_final     = w_issue && w_last_lane;
    assign in_ready    = !r_hold_valid || w_final;
    assign w_accept    = in_valid && in_ready;
    assign w_count     = (in_count > LANES_C) ? LANES_C : in_count;

    assign out_valid  = w_issue;
    assign out_last   = w_issue && r_hold_last && w_last_lane;
    assign credits    = r_cred;
    assign credit_err = r_credit_err;
    assign busy       = r_hold_valid;

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (r_lane == LW'(k)) begin
                out_data = r_hold_data[16*k +: 16];
            end
        end
    end

    // An empty word is consumed without touching the holding register,
    // so only the final-lane clear can change it in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_data  <= '0;
            r_hold_count <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_lane       <= '0;
        end else if (w_accept && (in_count != '0)) begin
            r_hold_data  <= in_data;
            r_hold_count <= w_count;
            r_hold_last  <= in_last;
            r_hold_valid <= 1'b1;
            r_lane       <= '0;
        end else if (w_final) begin
            r_hold_valid <= 1'b0;
            r_lane       <= '0;
        end else if (w_issue) begin
            r_lane       <= r_lane + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cred       <= CRED_MAX;
            r_credit_err <= 1'b0;
        end else if (w_issue && !credit_return) begin
            r_cred <= r_cred - 4'd1;
        end else if (credit_return && !w_issue) begin
            if (r_cred == CRED_MAX) begin
                r_credit_err <= 1'b1;
            end else begin
                r_cred <= r_cred + 4'd1;
            end
        end
    end

endmodule

// File: doc/sigmoid_feeder.md
# sigmoid_feeder

Upstream stage for the bf16 sigmoid unit. Accepts packed words of LANES bf16 operands over a valid/ready handshake, serializes them one lane per cycle onto the sigmoid's `valid_in`/`data_in`, and meters issue with a credit counter. The sigmoid pipeline has no backpressure, so credits are the only flow control. Credits mirror the free slots in the downstream result buffer, which returns one credit per result it drains.

## Interface
- `LANES`, default 4: bf16 lanes per input word (≥2).
- `CREDITS`, default 8: downstream result-buffer depth (1..15).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  feeder can accept a word this cycle.
- `in_data`  in  16*LANES  packed operands; lane k = bits [16k+15:16k]; lane 0 issues first.
- `in_count`  in  $clog2(LANES)+1  number of valid lanes, starting at lane 0; 0 = empty word.
- `in_last`  in  1  word ends a vector.
- `out_valid`  out  1  to sigmoid `valid_in`.
- `out_data`  out  16  to sigmoid `data_in`, raw bf16 with sign intact.
- `out_last`  out  1  final operand of a vector; travels beside the sigmoid pipeline.
- `credit_return`  in  1  one-cycle pulse; downstream freed one slot.
- `credits`  out  4  current credit count.
- `credit_err`  out  1  sticky; credit overflow detected.
- `busy`  out  1  holding register occupied.

## Operation
- State:
  - holding register: `hold_data`, `hold_count`, `hold_last`, `hold_valid`;
  - lane index `lane`, range 0..LANES-1;
  - credit counter `cred`, range 0..CREDITS;
  - `credit_err` flop.
- Issue condition: `issue = hold_valid && cred != 0`.
- Outputs (combinational from registered state):
  - `out_valid = issue`;
  - `out_data = hold_data` lane `lane`;
  - `out_last = issue && hold_last && (lane == hold_count-1)`.
- Final lane: `final = issue && lane == hold_count-1`.
  - `lane` advances by 1 on each issue.
  - On `final`, `lane` clears to 0 and the holding register empties unless a new word is accepted in the same cycle.
- `in_ready = !hold_valid || final`, giving back-to-back words with no bubble.
- Accepting a word (`in_valid && in_ready`):
  - `in_count` ≥ 1: load the holding register; `lane` = 0.
  - `in_count` = 0: the word is consumed and discarded, and the holding register is unchanged. If that word has `in_last` = 1, no `out_last` is generated for it.
  - `in_count` > LANES: clamped to LANES.
- Credits:
  - Issue and no return: `cred` − 1.
  - Return and no issue: `cred` + 1.
  - Issue and return in the same cycle: `cred` unchanged.
  - A return while `cred == CREDITS` and no issue is dropped and sets `credit_err`, which holds until reset.
- `credits` = `cred` zero-extended. `busy` = `hold_valid`.
- No interpretation of data: NaN, Inf and denormals pass through unchanged.

## Timing
- Reset values:
  - `hold_valid` = 0, `lane` = 0, `cred` = CREDITS, `credit_err` = 0;
  - therefore `out_valid` = 0, `out_last` = 0, `busy` = 0, `in_ready` = 1, `credits` = CREDITS;
  - `out_data` = 0, because the holding data also resets to 0.
- Word accepted at the edge ending cycle N: lane 0 appears on `out_valid` in cycle N+1 if `cred` > 0.
- With credits available, a full word issues on LANES consecutive cycles. A continuous input stream gives 100% issue rate.
- Credit starvation:
  - `out_valid` drops and `lane` holds.
  - A `credit_return` in cycle M allows issue in cycle M+1.
- `in_data`, `in_count` and `in_last` are sampled only at the handshake edge and may change freely otherwise.
- Reset mid-word discards the remaining lanes and clears all state. Credits in flight are the system's responsibility, because reset also restores `cred` = CREDITS.

## Test plan
- **Single full word.** Reset, then drive one word with lanes {0x3F80, 0xC000, 0x0000, 0x40C0}, `in_count` = 4, `in_last` = 1.
  - Expect `out_data` 0x3F80, 0xC000, 0x0000, 0x40C0 on 4 consecutive cycles starting 1 cycle after accept.
  - Expect `out_last` only on 0x40C0, and `credits` 8→4.
- **Back-to-back streaming.** Hold `in_valid` high for 3 words and pulse `credit_return` every cycle.
  - Expect 12 contiguous `out_valid` cycles.
  - Expect `in_ready` high exactly on the final-lane cycles (plus the first cycle).
- **Credit starvation.** `CREDITS` = 8, no returns, send 3 full words.
  - Expect exactly 8 issues, then `out_valid` = 0 with `lane` = 0 and `in_ready` = 0.
  - A single `credit_return` pulse yields exactly one more issue, on the next cycle.
- **Partial and empty words.**
  - Word with `in_count` = 1 and `in_last` = 1: exactly one issue, with `out_last` = 1.
  - Word with `in_count` = 0: accepted with no issue and no `out_last`.
  - Word with `in_count` = 7: issues 4 lanes.
- **Credit edge cases.**
  - `credit_return` with `cred` = 8 and no issue: `cred` stays 8 and `credit_err` rises and stays high.
  - Simultaneous issue and return at `cred` = 3: `cred` stays 3.
- **Reset mid-word.** Assert `rst` asynchronously after lane 1 has issued.
  - Expect `out_valid` = 0 immediately, without waiting for a clock edge.
  - After release: `credits` = 8, `in_ready` = 1, and no leftover lanes issue.
